vip_cfg_slave: RTL and testbench
================================

Name: vip_cfg_slave

Overview:
- Avalon-MM register responder that terminates the VIP configuration write stream: scaler, mixer and video-mode register sets.
- Captures writes into per-unit shadow registers. A Go write arms a commit; the shadow is copied to the active outputs at the next frame boundary.
- Sits between the configuration master and the timing generator, scaler and mixer. It is the behavioural/RTL stand-in for the VIP IP control slaves.

Parameters:
- WAIT_CYCLES, 2: cycles waitrequest stays high after each accepted write (0 = never stall).
- DW, 12: stored field width; writedata[DW-1:0] is kept, upper bits are ignored.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- address  in  9  [8:7] unit (0 scaler, 1 mixer, 2 mode, 3 unused); [6:0] register index
- write  in  1  write request
- writedata  in  32  write data
- read  in  1  read request
- waitrequest  out  1  stall
- readdata  out  32  read data
- readdatavalid  out  1  read response strobe
- frame_start  in  1  one-cycle pulse at start of frame
- mode_w, mode_h, mode_hfp, mode_hs, mode_hb, mode_vfp, mode_vs, mode_vb  out  DW each  active timing
- mode_ilace  out  1  active interlace flag (reg 5 bit0)
- scl_w, scl_h  out  DW each  active scaler output size
- mix_bkg_w, mix_bkg_h, mix_posx, mix_posy  out  DW each  active mixer geometry
- mix_en  out  1  active layer-0 enable
- pending  out  3  armed-commit flag per unit
- upd  out  3  one-cycle commit pulse per unit

Behaviour:
- Reset: all outputs, shadows, pending, busy counter and the mode valid bit clear to 0; waitrequest=0.
- Write handshake:
  - A write is accepted in a cycle with write=1 and waitrequest=0.
  - waitrequest goes high the next cycle and stays high for exactly WAIT_CYCLES cycles, then drops.
  - Writes to unused units or indices are accepted, consume the wait and change nothing.
- Register map:
  - Scaler: 3 = w, 4 = h.
  - Mixer: 3 = bkg_w, 4 = bkg_h, 8 = posx, 9 = posy, 10 = en (bit0).
  - Mode: 4 = bank (stored only), 5 = ilace, 6 = w, 7 = h, 9 = hfp, 10 = hs, 11 = hb, 12 = vfp, 13 = vs, 14 = vb, 30 = valid (bit0).
  - All units: index 0 = Go.
- Go: a write of bit0=1 sets pending[unit]; bit0=0 clears pending[unit].
- Commit:
  - Triggered on a frame_start cycle with pending[u]=1.
  - Active regs of unit u take their shadow values on the next edge; pending[u] clears; upd[u]=1 for that one cycle.
  - Mode commits only if shadow valid=1; otherwise pending[2] stays set and the commit retries on each later frame_start.
- Same-cycle events:
  - Go write and frame_start in the same cycle: frame_start samples the old pending, so the commit happens at the following frame.
  - Shadow write and committing frame_start in the same cycle: active takes the pre-write shadow; the write lands in the shadow only.
  - write and read together: the write wins and the read is dropped.
- Read:
  - Accepted when read=1 and waitrequest=0; reads never raise waitrequest.
  - readdatavalid pulses exactly one cycle later; readdata holds the zero-extended shadow value (Go index returns pending bit).
  - Unmapped addresses read 0. readdata holds its value between responses.
- Reset mid-operation: the busy counter aborts, waitrequest drops the next cycle, no upd pulse, no pending outstanding read response.

Optional Feature:
- VIP_CFG_READBACK_EN defined: the read path is as described.
- Undefined: read is ignored, readdata=0 and readdatavalid=0 permanently; the read mux is not instantiated.

Decomposition:
- Package vip_cfg_pkg holds:
  - unit codes (UNIT_SCL=0, UNIT_MIX=1, UNIT_MODE=2);
  - register index constants (REG_GO=0, REG_VALID=30, etc.);
  - typedef mode_regs_t (packed struct of the mode fields);
  - typedef mix_regs_t.
- One sub-module, vip_cfg_waitgen: accept detection plus the WAIT_CYCLES busy counter driving waitrequest.

Test Plan:
- WAIT_CYCLES=2: write scaler reg 3 = 0x500 -> waitrequest high exactly 2 cycles after the accept; scl_w stays 0.
- Write scaler w=1280, h=720, Go=1, then frame_start -> scl_w=1280 and scl_h=720 one cycle after frame_start; upd=3'b001 for one cycle; pending[0]=0.
- Mode: write fields, Go=1 with valid=0 -> frame_start gives no commit and pending[2] stays 1; write valid=1 -> next frame_start commits and upd[2] pulses.
- Shadow write of mix_posx=100 in the same cycle as a committing frame_start with shadow posx=40 -> mix_posx=40; readback of reg 8 returns 100.
- Go write coincident with frame_start -> no upd that cycle; upd[1] pulses at the next frame_start.
- With VIP_CFG_READBACK_EN: read address {2'd2, 7'd6} after w=800 -> readdatavalid one cycle later, readdata=32'd800. Without the macro: readdatavalid never asserts.

Source files
------------

// File: rtl/vip_cfg_pkg.sv
// Shared unit codes, register indices and shadow/active register layouts
// for the VIP configuration slave.
package vip_cfg_pkg;

  localparam int FIELD_W = 32;
  typedef logic [FIELD_W-1:0] cfg_word_t;

  typedef enum logic [1:0] {
    UNIT_SCL  = 2'd0,
    UNIT_MIX  = 2'd1,
    UNIT_MODE = 2'd2,
    UNIT_NONE = 2'd3
  } unit_e;

  localparam logic [6:0] REG_GO         = 7'd0;
  localparam logic [6:0] REG_SCL_W      = 7'd3;
  localparam logic [6:0] REG_SCL_H      = 7'd4;
  localparam logic [6:0] REG_MIX_BKG_W  = 7'd3;
  localparam logic [6:0] REG_MIX_BKG_H  = 7'd4;
  localparam logic [6:0] REG_MIX_POSX   = 7'd8;
  localparam logic [6:0] REG_MIX_POSY   = 7'd9;
  localparam logic [6:0] REG_MIX_EN     = 7'd10;
  localparam logic [6:0] REG_MODE_BANK  = 7'd4;
  localparam logic [6:0] REG_MODE_ILACE = 7'd5;
  localparam logic [6:0] REG_MODE_W     = 7'd6;
  localparam logic [6:0] REG_MODE_H     = 7'd7;
  localparam logic [6:0] REG_MODE_HFP   = 7'd9;
  localparam logic [6:0] REG_MODE_HS    = 7'd10;
  localparam logic [6:0] REG_MODE_HB    = 7'd11;
  localparam logic [6:0] REG_MODE_VFP   = 7'd12;
  localparam logic [6:0] REG_MODE_VS    = 7'd13;
  localparam logic [6:0] REG_MODE_VB    = 7'd14;
  localparam logic [6:0] REG_VALID      = 7'd30;

  typedef struct packed {
    cfg_word_t w;
    cfg_word_t h;
  } scl_regs_t;

  typedef struct packed {
    cfg_word_t bkg_w;
    cfg_word_t bkg_h;
    cfg_word_t posx;
    cfg_word_t posy;
    logic      en;
  } mix_regs_t;

  typedef struct packed {
    cfg_word_t bank;
    logic      ilace;
    cfg_word_t w;
    cfg_word_t h;
    cfg_word_t hfp;
    cfg_word_t hs;
    cfg_word_t hb;
    cfg_word_t vfp;
    cfg_word_t vs;
    cfg_word_t vb;
    logic      valid;
  } mode_regs_t;

  // Fields are held in full words but only the low dw bits are ever non-zero.
  function automatic cfg_word_t fieldMask(input int unsigned dw);
    return (dw >= FIELD_W) ? '1 : ((cfg_word_t'(1) << dw) - cfg_word_t'(1));
  endfunction

endpackage

// File: rtl/vip_cfg_waitgen.sv
// Write accept detection and the post-write stall counter that drives
// waitrequest for the VIP configuration slave.
module vip_cfg_waitgen #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic write_i,
  output logic accept_o,
  output logic waitrequest_o
);

  localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  logic [CW-1:0] busy_q, busy_d;

  assign waitrequest_o = (busy_q != '0);
  assign accept_o      = write_i & ~waitrequest_o;

  always_comb begin
    busy_d = busy_q;
    if (accept_o) begin
      busy_d = CW'(WAIT_CYCLES);
    end else if (busy_q != '0) begin
      busy_d = busy_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/vip_cfg_slave.sv
// Avalon-MM configuration responder: shadow registers per unit, committed to
// active outputs on frame_start after a Go. Readback via VIP_CFG_READBACK_EN.
module vip_cfg_slave
  import vip_cfg_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DW          = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [8:0]    address_i,
  input  logic          write_i,
  input  logic [31:0]   writedata_i,
  input  logic          read_i,
  output logic          waitrequest_o,
  output logic [31:0]   readdata_o,
  output logic          readdatavalid_o,
  input  logic          frame_start_i,
  output logic [DW-1:0] mode_w_o,
  output logic [DW-1:0] mode_h_o,
  output logic [DW-1:0] mode_hfp_o,
  output logic [DW-1:0] mode_hs_o,
  output logic [DW-1:0] mode_hb_o,
  output logic [DW-1:0] mode_vfp_o,
  output logic [DW-1:0] mode_vs_o,
  output logic [DW-1:0] mode_vb_o,
  output logic          mode_ilace_o,
  output logic [DW-1:0] scl_w_o,
  output logic [DW-1:0] scl_h_o,
  output logic [DW-1:0] mix_bkg_w_o,
  output logic [DW-1:0] mix_bkg_h_o,
  output logic [DW-1:0] mix_posx_o,
  output logic [DW-1:0] mix_posy_o,
  output logic          mix_en_o,
  output logic [2:0]    pending_o,
  output logic [2:0]    upd_o
);

  localparam cfg_word_t MASK = fieldMask(DW);

  logic       wrAccept;
  unit_e      accUnit;
  logic [6:0] regIdx;
  cfg_word_t  wrField;
  logic       wrBit;

  scl_regs_t  sclSh_q, sclSh_d, sclAct_q, sclAct_d;
  mix_regs_t  mixSh_q, mixSh_d, mixAct_q, mixAct_d;
  mode_regs_t modeSh_q, modeSh_d, modeAct_q, modeAct_d;
  logic [2:0] pend_q, pend_d, upd_q, upd_d;

  vip_cfg_waitgen #(.WAIT_CYCLES(WAIT_CYCLES)) u_waitgen (
    .clk          (clk),
    .reset        (reset),
    .write_i      (write_i),
    .accept_o     (wrAccept),
    .waitrequest_o(waitrequest_o)
  );

  assign accUnit = unit_e'(address_i[8:7]);
  assign regIdx  = address_i[6:0];
  assign wrField = writedata_i & MASK;
  assign wrBit   = writedata_i[0];

  // Commits read the registered shadow/pending, so a same-cycle write only
  // reaches the shadow and a same-cycle Go only arms the following frame.
  always_comb begin
    sclSh_d   = sclSh_q;
    mixSh_d   = mixSh_q;
    modeSh_d  = modeSh_q;
    sclAct_d  = sclAct_q;
    mixAct_d  = mixAct_q;
    modeAct_d = modeAct_q;
    pend_d    = pend_q;
    upd_d     = '0;

    if (frame_start_i) begin
      if (pend_q[0]) begin
        sclAct_d  = sclSh_q;
        pend_d[0] = 1'b0;
        upd_d[0]  = 1'b1;
      end
      if (pend_q[1]) begin
        mixAct_d  = mixSh_q;
        pend_d[1] = 1'b0;
        upd_d[1]  = 1'b1;
      end
      if (pend_q[2] && modeSh_q.valid) begin
        modeAct_d = modeSh_q;
        pend_d[2] = 1'b0;
        upd_d[2]  = 1'b1;
      end
    end

    if (wrAccept) begin
      case (accUnit)
        UNIT_SCL: begin
          case (regIdx)
            REG_GO:    pend_d[0] = wrBit;
            REG_SCL_W: sclSh_d.w = wrField;
            REG_SCL_H: sclSh_d.h = wrField;
            default: ;
          endcase
        end
        UNIT_MIX: begin
          case (regIdx)
            REG_GO:        pend_d[1]     = wrBit;
            REG_MIX_BKG_W: mixSh_d.bkg_w = wrField;
            REG_MIX_BKG_H: mixSh_d.bkg_h = wrField;
            REG_MIX_POSX:  mixSh_d.posx  = wrField;
            REG_MIX_POSY:  mixSh_d.posy  = wrField;
            REG_MIX_EN:    mixSh_d.en    = wrBit;
            default: ;
          endcase
        end
        UNIT_MODE: begin
          case (regIdx)
            REG_GO:         pend_d[2]      = wrBit;
            REG_MODE_BANK:  modeSh_d.bank  = wrField;
            REG_MODE_ILACE: modeSh_d.ilace = wrBit;
            REG_MODE_W:     modeSh_d.w     = wrField;
            REG_MODE_H:     modeSh_d.h     = wrField;
            REG_MODE_HFP:   modeSh_d.hfp   = wrField;
            REG_MODE_HS:    modeSh_d.hs    = wrField;
            REG_MODE_HB:    modeSh_d.hb    = wrField;
            REG_MODE_VFP:   modeSh_d.vfp   = wrField;
            REG_MODE_VS:    modeSh_d.vs    = wrField;
            REG_MODE_VB:    modeSh_d.vb    = wrField;
            REG_VALID:      modeSh_d.valid = wrBit;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclSh_q   <= '0;
      mixSh_q   <= '0;
      modeSh_q  <= '0;
      sclAct_q  <= '0;
      mixAct_q  <= '0;
      modeAct_q <= '0;
      pend_q    <= '0;
      upd_q     <= '0;
    end else begin
      sclSh_q   <= sclSh_d;
      mixSh_q   <= mixSh_d;
      modeSh_q  <= modeSh_d;
      sclAct_q  <= sclAct_d;
      mixAct_q  <= mixAct_d;
      modeAct_q <= modeAct_d;
      pend_q    <= pend_d;
      upd_q     <= upd_d;
    end
  end

  assign scl_w_o      = sclAct_q.w[DW-1:0];
  assign scl_h_o      = sclAct_q.h[DW-1:0];
  assign mix_bkg_w_o  = mixAct_q.bkg_w[DW-1:0];
  assign mix_bkg_h_o  = mixAct_q.bkg_h[DW-1:0];
  assign mix_posx_o   = mixAct_q.posx[DW-1:0];
  assign mix_posy_o   = mixAct_q.posy[DW-1:0];
  assign mix_en_o     = mixAct_q.en;
  assign mode_w_o     = modeAct_q.w[DW-1:0];
  assign mode_h_o     = modeAct_q.h[DW-1:0];
  assign mode_hfp_o   = modeAct_q.hfp[DW-1:0];
  assign mode_hs_o    = modeAct_q.hs[DW-1:0];
  assign mode_hb_o    = modeAct_q.hb[DW-1:0];
  assign mode_vfp_o   = modeAct_q.vfp[DW-1:0];
  assign mode_vs_o    = modeAct_q.vs[DW-1:0];
  assign mode_vb_o    = modeAct_q.vb[DW-1:0];
  assign mode_ilace_o = modeAct_q.ilace;
  assign pending_o    = pend_q;
  assign upd_o        = upd_q;

  // Masked-off upper bits, bank and valid never leave the active copies.
  logic unusedActive;
  assign unusedActive = ^{sclAct_q, mixAct_q, modeAct_q};

`ifdef VIP_CFG_READBACK_EN
  logic      rdAccept;
  cfg_word_t rdMux;
  logic      rvalid_q;
  cfg_word_t rdata_q;

  assign rdAccept = read_i & ~waitrequest_o & ~write_i;

  always_comb begin
    rdMux = '0;
    case (accUnit)
      UNIT_SCL: begin
        case (regIdx)
          REG_GO:    rdMux = {31'd0, pend_q[0]};
          REG_SCL_W: rdMux = sclSh_q.w;
          REG_SCL_H: rdMux = sclSh_q.h;
          default: ;
        endcase
      end
      UNIT_MIX: begin
        case (regIdx)
          REG_GO:        rdMux = {31'd0, pend_q[1]};
          REG_MIX_BKG_W: rdMux = mixSh_q.bkg_w;
          REG_MIX_BKG_H: rdMux = mixSh_q.bkg_h;
          REG_MIX_POSX:  rdMux = mixSh_q.posx;
          REG_MIX_POSY:  rdMux = mixSh_q.posy;
          REG_MIX_EN:    rdMux = {31'd0, mixSh_q.en};
          default: ;
        endcase
      end
      UNIT_MODE: begin
        case (regIdx)
          REG_GO:         rdMux = {31'd0, pend_q[2]};
          REG_MODE_BANK:  rdMux = modeSh_q.bank;
          REG_MODE_ILACE: rdMux = {31'd0, modeSh_q.ilace};
          REG_MODE_W:     rdMux = modeSh_q.w;
          REG_MODE_H:     rdMux = modeSh_q.h;
          REG_MODE_HFP:   rdMux = modeSh_q.hfp;
          REG_MODE_HS:    rdMux = modeSh_q.hs;
          REG_MODE_HB:    rdMux = modeSh_q.hb;
          REG_MODE_VFP:   rdMux = modeSh_q.vfp;
          REG_MODE_VS:    rdMux = modeSh_q.vs;
          REG_MODE_VB:    rdMux = modeSh_q.vb;
          REG_VALID:      rdMux = {31'd0, modeSh_q.valid};
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rdAccept;
      if (rdAccept) begin
        rdata_q <= rdMux;
      end
    end
  end

  assign readdata_o      = rdata_q;
  assign readdatavalid_o = rvalid_q;
`else
  logic unusedRead;
  assign unusedRead      = read_i;
  assign readdata_o      = '0;
  assign readdatavalid_o = 1'b0;
`endif

endmodule

// File: tb/tb_vip_cfg_slave.sv
// Directed self-checking bench for vip_cfg_slave (WAIT_CYCLES=2, DW=12);
// readback checks follow VIP_CFG_READBACK_EN.
module tb_vip_cfg_slave;

  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [8:0]    address = '0;
  logic          write = 1'b0;
  logic [31:0]   writedata = '0;
  logic          read = 1'b0;
  logic          frameStart = 1'b0;
  logic          waitrequest;
  logic [31:0]   readdata;
  logic          readdatavalid;
  logic [DW-1:0] modeW, modeH, modeHfp, modeHs, modeHb, modeVfp, modeVs, modeVb;
  logic          modeIlace;
  logic [DW-1:0] sclW, sclH, mixBkgW, mixBkgH, mixPosx, mixPosy;
  logic          mixEn;
  logic [2:0]    pending, upd;

  int checks = 0;
  int errors = 0;

  vip_cfg_slave #(.WAIT_CYCLES(2), .DW(DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .address_i      (address),
    .write_i        (write),
    .writedata_i    (writedata),
    .read_i         (read),
    .waitrequest_o  (waitrequest),
    .readdata_o     (readdata),
    .readdatavalid_o(readdatavalid),
    .frame_start_i  (frameStart),
    .mode_w_o       (modeW),
    .mode_h_o       (modeH),
    .mode_hfp_o     (modeHfp),
    .mode_hs_o      (modeHs),
    .mode_hb_o      (modeHb),
    .mode_vfp_o     (modeVfp),
    .mode_vs_o      (modeVs),
    .mode_vb_o      (modeVb),
    .mode_ilace_o   (modeIlace),
    .scl_w_o        (sclW),
    .scl_h_o        (sclH),
    .mix_bkg_w_o    (mixBkgW),
    .mix_bkg_h_o    (mixBkgH),
    .mix_posx_o     (mixPosx),
    .mix_posy_o     (mixPosy),
    .mix_en_o       (mixEn),
    .pending_o      (pending),
    .upd_o          (upd)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [8:0] ad(input logic [1:0] unit, input logic [6:0] idx);
    return {unit, idx};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitReady();
    for (int i = 0; i < 16 && waitrequest !== 1'b0; i++) tick();
    checkOutput("ready_before_access", {31'd0, waitrequest}, 32'd0);
  endtask

  task automatic applyStimulus(input logic [8:0] addr, input logic [31:0] data);
    waitReady();
    address   = addr;
    writedata = data;
    write     = 1'b1;
    tick();
    write     = 1'b0;
  endtask

  task automatic pulseFrame();
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
  endtask

`ifdef VIP_CFG_READBACK_EN
  task automatic readReg(input string tag, input logic [8:0] addr, input logic [31:0] exp);
    waitReady();
    address = addr;
    read    = 1'b1;
    tick();
    read    = 1'b0;
    checkOutput({tag, "_valid"}, {31'd0, readdatavalid}, 32'd1);
    checkOutput(tag, readdata, exp);
  endtask
`endif

  initial begin
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;

    checkOutput("rst_waitrequest", {31'd0, waitrequest}, 32'd0);
    checkOutput("rst_scl_w", {20'd0, sclW}, 32'd0);
    checkOutput("rst_mode_w", {20'd0, modeW}, 32'd0);
    checkOutput("rst_mix_en", {31'd0, mixEn}, 32'd0);
    checkOutput("rst_pending", {29'd0, pending}, 32'd0);
    checkOutput("rst_upd", {29'd0, upd}, 32'd0);
    checkOutput("rst_rvalid", {31'd0, readdatavalid}, 32'd0);
    checkOutput("rst_readdata", readdata, 32'd0);

    // Stall window after a single accepted write
    address = ad(2'd0, 7'd3); writedata = 32'h500; write = 1'b1;
    tick();
    write = 1'b0;
    checkOutput("wait_cycle1", {31'd0, waitrequest}, 32'd1);
    tick();
    checkOutput("wait_cycle2", {31'd0, waitrequest}, 32'd1);
    tick();
    checkOutput("wait_dropped", {31'd0, waitrequest}, 32'd0);
    checkOutput("scl_w_uncommitted", {20'd0, sclW}, 32'd0);

    // Scaler commit
    applyStimulus(ad(2'd0, 7'd3), 32'd1280);
    applyStimulus(ad(2'd0, 7'd4), 32'd720);
    applyStimulus(ad(2'd0, 7'd0), 32'd1);
    checkOutput("scl_pending_armed", {29'd0, pending}, 32'd1);
    checkOutput("scl_w_before_frame", {20'd0, sclW}, 32'd0);
    pulseFrame();
    checkOutput("scl_w_commit", {20'd0, sclW}, 32'd1280);
    checkOutput("scl_h_commit", {20'd0, sclH}, 32'd720);
    checkOutput("scl_upd", {29'd0, upd}, 32'b001);
    checkOutput("scl_pending_clr", {29'd0, pending}, 32'd0);
    tick();
    checkOutput("scl_upd_onecycle", {29'd0, upd}, 32'd0);

    // Upper write data bits are discarded
    applyStimulus(ad(2'd0, 7'd3), 32'hFFFF_F123);
    applyStimulus(ad(2'd0, 7'd0), 32'd1);
    pulseFrame();
    checkOutput("scl_w_truncated", {20'd0, sclW}, 32'h123);
    checkOutput("scl_h_kept", {20'd0, sclH}, 32'd720);

    // Unused unit: accepted, nothing changes
    applyStimulus(ad(2'd3, 7'd0), 32'd1);
    checkOutput("unused_unit_wait", {31'd0, waitrequest}, 32'd1);
    checkOutput("unused_unit_pending", {29'd0, pending}, 32'd0);

    // Mode commit gated on valid
    applyStimulus(ad(2'd2, 7'd6), 32'd800);
    applyStimulus(ad(2'd2, 7'd7), 32'd600);
    applyStimulus(ad(2'd2, 7'd9), 32'd40);
    applyStimulus(ad(2'd2, 7'd14), 32'd36);
    applyStimulus(ad(2'd2, 7'd5), 32'd1);
    applyStimulus(ad(2'd2, 7'd0), 32'd1);
    pulseFrame();
    checkOutput("mode_invalid_upd", {29'd0, upd}, 32'd0);
    checkOutput("mode_invalid_w", {20'd0, modeW}, 32'd0);
    checkOutput("mode_invalid_pending", {29'd0, pending}, 32'b100);
    applyStimulus(ad(2'd2, 7'd30), 32'd1);
    pulseFrame();
    checkOutput("mode_upd", {29'd0, upd}, 32'b100);
    checkOutput("mode_w", {20'd0, modeW}, 32'd800);
    checkOutput("mode_h", {20'd0, modeH}, 32'd600);
    checkOutput("mode_hfp", {20'd0, modeHfp}, 32'd40);
    checkOutput("mode_vb", {20'd0, modeVb}, 32'd36);
    checkOutput("mode_ilace", {31'd0, modeIlace}, 32'd1);
    checkOutput("mode_pending_clr", {29'd0, pending}, 32'd0);

    // Shadow write coincident with a committing frame
    applyStimulus(ad(2'd1, 7'd8), 32'd40);
    applyStimulus(ad(2'd1, 7'd0), 32'd1);
    waitReady();
    address = ad(2'd1, 7'd8); writedata = 32'd100; write = 1'b1; frameStart = 1'b1;
    tick();
    write = 1'b0; frameStart = 1'b0;
    checkOutput("mix_posx_old_shadow", {20'd0, mixPosx}, 32'd40);
    checkOutput("mix_upd", {29'd0, upd}, 32'b010);
`ifdef VIP_CFG_READBACK_EN
    readReg("rd_mix_posx", ad(2'd1, 7'd8), 32'd100);
`endif
    applyStimulus(ad(2'd1, 7'd0), 32'd1);
    pulseFrame();
    checkOutput("mix_posx_new", {20'd0, mixPosx}, 32'd100);

    // Go coincident with frame only arms the following frame
    applyStimulus(ad(2'd1, 7'd9), 32'd7);
    applyStimulus(ad(2'd1, 7'd10), 32'd1);
    waitReady();
    address = ad(2'd1, 7'd0); writedata = 32'd1; write = 1'b1; frameStart = 1'b1;
    tick();
    write = 1'b0; frameStart = 1'b0;
    checkOutput("go_frame_no_upd", {29'd0, upd}, 32'd0);
    checkOutput("go_frame_pending", {29'd0, pending}, 32'b010);
    checkOutput("go_frame_posy_old", {20'd0, mixPosy}, 32'd0);
    pulseFrame();
    checkOutput("go_next_upd", {29'd0, upd}, 32'b010);
    checkOutput("go_next_posy", {20'd0, mixPosy}, 32'd7);
    checkOutput("go_next_en", {31'd0, mixEn}, 32'd1);

    // Go=0 disarms
    applyStimulus(ad(2'd0, 7'd0), 32'd1);
    applyStimulus(ad(2'd0, 7'd0), 32'd0);
    pulseFrame();
    checkOutput("go_cleared_upd", {29'd0, upd}, 32'd0);

`ifdef VIP_CFG_READBACK_EN
    readReg("rd_mode_w", ad(2'd2, 7'd6), 32'd800);
    tick();
    checkOutput("rd_valid_onecycle", {31'd0, readdatavalid}, 32'd0);
    checkOutput("rd_data_held", readdata, 32'd800);
    readReg("rd_mode_valid", ad(2'd2, 7'd30), 32'd1);
    readReg("rd_unmapped", ad(2'd1, 7'd5), 32'd0);
    applyStimulus(ad(2'd2, 7'd0), 32'd1);
    readReg("rd_go_pending", ad(2'd2, 7'd0), 32'd1);
    waitReady();
    address = ad(2'd2, 7'd0); writedata = 32'd0; write = 1'b1; read = 1'b1;
    tick();
    write = 1'b0; read = 1'b0;
    checkOutput("rd_dropped_by_write", {31'd0, readdatavalid}, 32'd0);
`else
    waitReady();
    address = ad(2'd2, 7'd6); read = 1'b1;
    tick();
    checkOutput("no_rd_valid1", {31'd0, readdatavalid}, 32'd0);
    tick();
    read = 1'b0;
    checkOutput("no_rd_valid2", {31'd0, readdatavalid}, 32'd0);
    checkOutput("no_rd_data", readdata, 32'd0);
`endif

    // Reset mid-operation
    applyStimulus(ad(2'd0, 7'd0), 32'd1);
    reset = 1'b1; frameStart = 1'b1;
    tick();
    reset = 1'b0; frameStart = 1'b0;
    checkOutput("midrst_waitrequest", {31'd0, waitrequest}, 32'd0);
    checkOutput("midrst_upd", {29'd0, upd}, 32'd0);
    checkOutput("midrst_pending", {29'd0, pending}, 32'd0);
    checkOutput("midrst_scl_w", {20'd0, sclW}, 32'd0);
    checkOutput("midrst_rvalid", {31'd0, readdatavalid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
